// File: rtl/mips_16_imem_loader.sv
// Byte-stream program loader for the mips_16 instruction memory.
// Holds the core in reset until a counted, checksummed load completes.
module mips_16_imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [15:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  done,
    output logic                  err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [31:0]   MAXW = 32'd1 << ADDR_WIDTH;
    localparam logic [CW-1:0] MAXN = CW'(1) << ADDR_WIDTH;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic                  r_rx_ready;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_wdata;
    logic                  r_core_rst;
    logic                  r_done;
    logic                  r_err;
    logic [CW-1:0]         r_total;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [7:0]            r_hi;
    logic [7:0]            r_sum;
    logic                  w_acc;
    logic                  w_idle_like;
    logic                  w_clamp;
    logic [CW-1:0]         w_n;
    logic                  w_last;

    assign w_acc       = rx_valid && r_rx_ready;
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE)
                      || (r_state == S_ERR);
    // COUNT of zero means a full memory; oversize counts saturate.
    assign w_clamp     = (rx_data == 8'd0) || (32'(rx_data) > MAXW);
    assign w_n         = w_clamp ? MAXN : CW'(rx_data);
    assign w_last      = (r_cnt + CW'(1)) == r_total;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: if (start) w_next = S_COUNT;
            S_COUNT: if (w_acc) w_next = S_HI;
            S_HI:    if (w_acc) w_next = S_LO;
            S_LO:    if (w_acc) w_next = w_last ? S_CHECK : S_HI;
            S_CHECK: if (w_acc) w_next = (r_sum == rx_data) ? S_DONE : S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_total    <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_hi       <= '0;
            r_sum      <= '0;
        end else begin
            r_state    <= w_next;
            r_rx_ready <= (w_next == S_COUNT) || (w_next == S_HI)
                       || (w_next == S_LO) || (w_next == S_CHECK);
            r_done     <= (w_next == S_DONE);
            r_err      <= (w_next == S_ERR);
            r_core_rst <= (w_next != S_DONE);
            r_we       <= 1'b0;
            if (start && w_idle_like) begin
                r_cnt <= '0;
                r_idx <= '0;
                r_sum <= '0;
            end
            if (w_acc) begin
                unique case (r_state)
                    S_COUNT: r_total <= w_n;
                    S_HI: begin
                        r_hi  <= rx_data;
                        r_sum <= r_sum ^ rx_data;
                    end
                    S_LO: begin
                        r_sum   <= r_sum ^ rx_data;
                        r_we    <= 1'b1;
                        r_addr  <= r_idx;
                        r_wdata <= {r_hi, rx_data};
                        r_idx   <= r_idx + 1'b1;
                        r_cnt   <= r_cnt + CW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx_ready   = r_rx_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign core_rst   = r_core_rst;
    assign done       = r_done;
    assign err        = r_err;

endmodule
